keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Sequential front end for the 4x4 keypad. It drives the row lines one at a time (active-low), synchronizes and samples the raw column lines, and debounces across whole scan frames. It emits a one-cycle `key_valid` pulse with the 4-bit key code once per debounced press, plus a `key_held` level. It sits directly upstream of the combinational row/column decoder and uses the same key map and priority, so downstream logic sees only clean, single-shot key events.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each row is driven. Minimum 4.
- `DEBOUNCE_FRAMES`, default 4: consecutive identical frames needed to accept a press or a release. Range 2..255.
- `clk`  in  1: single clock for all logic.
- `rst_n`  in  1: asynchronous, active-low reset.
- `col`  in  4: raw column lines, active-low, pulled up externally, asynchronous to `clk`.
- `row`  out  4: row drive, active-low one-hot.
- `key`  out  4: code of the last accepted key. Valid whenever `key_held`=1 and on the `key_valid` cycle.
- `key_valid`  out  1: one-cycle pulse per accepted press.
- `key_held`  out  1: high from the accepted press until the accepted release.

## Operation
- **Column synchronizer:** two-flop synchronizer on `col`, reset to 4'b1111. All decisions use the synchronized value.
- **Row scan:**
  - Dwell counter `div` counts 0..SCAN_DIV-1, width $clog2(SCAN_DIV).
  - Row index `idx` advances 0→1→2→3→0 when `div`=SCAN_DIV-1.
  - `row` = ~(1<<idx), registered.
- **Sample point:** the synchronized column is sampled only in the cycle where `div`=SCAN_DIV-1, i.e. the last dwell cycle of each row.
- **Frame capture:**
  - A frame is rows 0..3.
  - The first hit in scan order wins: lowest row, then lowest column with `col` low. Later hits in the same frame are ignored.
  - The frame result (`hit`, `code`) is evaluated at frame end (`idx`=3, `div`=SCAN_DIV-1, sample of row 3 included). The capture state then clears for the next frame.
- **Key map (row r, col c → code):**
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- **Debounce FSM:** updates only on frame-end edges. Counter `cnt` has width $clog2(DEBOUNCE_FRAMES+1).
  - **IDLE:** hit → `cand`=code, `cnt`=1, go to DEBOUNCE. No hit → stay.
  - **DEBOUNCE:**
    - Hit with code==`cand` → `cnt`+1. Reaching DEBOUNCE_FRAMES → PRESSED, `key`<=`cand`, pulse `key_valid`.
    - Hit with a different code → `cand`=code, `cnt`=1.
    - No hit → IDLE.
  - **PRESSED:**
    - No hit → RELEASE, `cnt`=1.
    - Any hit (same or different code) → stay. No new pulse; `key` is unchanged.
  - **RELEASE:**
    - No hit → `cnt`+1. Reaching DEBOUNCE_FRAMES → IDLE, `key_held`=0.
    - Hit → PRESSED; `key` is unchanged and there is no pulse.
- `key_held` = 1 in PRESSED and RELEASE.
- `key` holds its last value after release and is never cleared except by reset.

## Timing
- **Reset values:** `row`=4'b1110, `idx`=0, `div`=0, `key`=4'h0, `key_valid`=0, `key_held`=0, state IDLE, `cnt`=0, sync flops 4'b1111.
- **Reset mid-operation:** all of the above apply asynchronously; scanning restarts at row 0 after `rst_n` rises.
- **Row timing:** each row is driven for exactly SCAN_DIV cycles, so a frame is 4*SCAN_DIV cycles. The first row change occurs SCAN_DIV cycles after reset release.
- **Column settling:** the row changes at `div`=0 and the synchronized column reflects it 2 cycles later. The sample at `div`=SCAN_DIV-1 is therefore settled for SCAN_DIV≥4.
- **Outputs:** `key`, `key_valid` and `key_held` are registered and change in the cycle after the frame-end cycle.
- **Press latency:** if the first frame that sees a press is frame k, `key_valid` is high for exactly one cycle after the end of frame k+DEBOUNCE_FRAMES-1.
- **Release latency:** `key_held` falls after the end of the DEBOUNCE_FRAMES-th consecutive empty frame.
- **Pulse spacing:** `key_valid` is never asserted in two consecutive cycles. At most one pulse occurs per press/release cycle.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_FRAMES=3 (frame = 16 cycles). The bench keypad model drives `col[c]`=0 while `row[r]`=0 for each pressed (r,c).
- **Reset and scan order:** release reset, no keys → `row` = 1110, 1101, 1011, 0111, 1110 at cycles 0, 4, 8, 12, 16; `key`=0, `key_valid`=0 and `key_held`=0 throughout.
- **Clean press:** hold R1C2 for 6 frames then release → exactly one `key_valid` pulse, with `key`=4'h6, 1 cycle after the end of the 3rd frame seeing it. `key_held`=1 until the 3rd empty frame ends, then 0. `key` stays 6.
- **Bounce rejection:** press R0C0 for 2 frames, release 1 frame, press R0C0 again for 3 frames → no pulse during the first burst. One pulse with `key`=4'h1 after the 3rd frame of the second burst.
- **Priority:** R2C0 and R0C3 pressed simultaneously → `key`=4'hA. Pressing R3C1 while A is held → no new pulse, `key` stays A.
- **Key zero:** press R3C1 → `key_valid` pulse with `key`=4'h0 and `key_held`=1, distinguishable from idle.
- **Reset mid-press:** assert `rst_n` low while in PRESSED with R2C3 held → `key_held`, `key` and `key_valid` go to 0 immediately. After `rst_n` rises with the key still held, one new pulse with `key`=4'hC after 3 frames.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 keypad front end: active-low row scan, two-flop column synchronizer,
// first-hit-per-frame capture and frame-level press/release debounce.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_PRESSED,
    S_RELEASE
  } state_t;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Stage p0/p1: column synchronizer
  logic [3:0] col_p0, col_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_p0 <= 4'b1111;
      col_p1 <= 4'b1111;
    end else begin
      col_p0 <= col;
      col_p1 <= col_p0;
    end
  end

  // Row scan: dwell counter and row index
  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic          samp, frame_end;

  assign samp      = (div == DIV_LAST);
  assign frame_end = samp && (idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
      idx <= 2'd0;
      row <= 4'b1110;
    end else if (samp) begin
      div <= '0;
      idx <= idx + 2'd1;
      row <= ~(4'b0001 << (idx + 2'd1));
    end else begin
      div <= div + DW'(1);
    end
  end

  // Lowest active column of the row currently driven
  logic       row_hit;
  logic [3:0] row_code;

  always_comb begin
    row_hit  = 1'b0;
    row_code = 4'h0;
    for (int c = 3; c >= 0; c--) begin
      if (!col_p1[c]) begin
        row_hit  = 1'b1;
        row_code = key_code(idx, 2'(c));
      end
    end
  end

  // Frame capture: earliest hit in scan order is kept until frame end
  logic       acc_hit;
  logic [3:0] acc_code;
  logic       frame_hit;
  logic [3:0] frame_code;

  assign frame_hit  = acc_hit | row_hit;
  assign frame_code = acc_hit ? acc_code : row_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hit <= 1'b0;
    end else if (frame_end) begin
      acc_hit <= 1'b0;
    end else if (samp && row_hit) begin
      acc_hit <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (samp && !acc_hit && row_hit) begin
      acc_code <= row_code;
    end
  end

  // Debounce FSM, advanced once per frame
  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    cand, cand_d, key_d;
  logic          valid_d, held_d;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cand_d  = cand;
    key_d   = key;
    valid_d = 1'b0;
    if (frame_end) begin
      case (state)
        S_IDLE: begin
          if (frame_hit) begin
            cand_d  = frame_code;
            cnt_d   = CNT_ONE;
            state_d = S_DEBOUNCE;
          end
        end
        S_DEBOUNCE: begin
          if (!frame_hit) begin
            state_d = S_IDLE;
          end else if (frame_code == cand) begin
            cnt_d = cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              state_d = S_PRESSED;
              key_d   = cand;
              valid_d = 1'b1;
            end
          end else begin
            cand_d = frame_code;
            cnt_d  = CNT_ONE;
          end
        end
        S_PRESSED: begin
          if (!frame_hit) begin
            state_d = S_RELEASE;
            cnt_d   = CNT_ONE;
          end
        end
        S_RELEASE: begin
          if (frame_hit) begin
            state_d = S_PRESSED;
          end else begin
            cnt_d = cnt + CNT_ONE;
            if (cnt == CNT_LAST) begin
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    held_d = (state_d == S_PRESSED) || (state_d == S_RELEASE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cand      <= 4'h0;
      key       <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cand      <= cand_d;
      key       <= key_d;
      key_valid <= valid_d;
      key_held  <= held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad contact model, frame-level reference model
// built from run lengths of identical frames, directed and random key sequences.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int FRAME = 4 * SD;

  localparam logic [15:0] K_R0C0 = 16'h0001;
  localparam logic [15:0] K_R0C3 = 16'h0008;
  localparam logic [15:0] K_R1C2 = 16'h0040;
  localparam logic [15:0] K_R2C0 = 16'h0100;
  localparam logic [15:0] K_R2C3 = 16'h0800;
  localparam logic [15:0] K_R3C1 = 16'h2000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  col, row, key;
  logic        key_valid, key_held;
  logic [15:0] mask = '0;

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .col(col), .row(row),
    .key(key), .key_valid(key_valid), .key_held(key_held)
  );

  int total = 0, passed = 0, fails = 0;
  int cyc = 0, pulses = 0;

  logic       m_held, m_valid;
  logic [3:0] m_key, m_run_code;
  int         m_run, m_empty;

  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0; m_valid = 1'b0; m_key = 4'h0;
    m_run_code = 4'h0; m_run = 0; m_empty = 0;
  endtask

  // One whole frame with the current mask: the key with the lowest index wins.
  task automatic model_frame();
    logic       hit;
    logic [3:0] code;
    hit = 1'b0; code = 4'h0;
    for (int i = 0; i < 16; i++)
      if (!hit && mask[i]) begin hit = 1'b1; code = kmap[i]; end
    if (!m_held) begin
      if (hit) begin
        if (m_run > 0 && code == m_run_code) m_run++;
        else begin m_run_code = code; m_run = 1; end
        if (m_run == DB) begin
          m_held = 1'b1; m_key = code; m_valid = 1'b1; m_empty = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (hit) m_empty = 0;
      else m_empty++;
      if (m_empty == DB) begin
        m_held = 1'b0; m_run = 0;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    logic [3:0] er;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      m_valid = 1'b0;
      if (cyc % FRAME == 0) model_frame();
      er = 4'hF;
      er[(cyc % FRAME) / SD] = 1'b0;
      check("row", row, er);
      check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
      check("key_held", {3'b0, key_held}, {3'b0, m_held});
      check("key", key, m_key);
      if (key_valid) pulses++;
    end
  endtask

  task automatic frames(input logic [15:0] m, input int n);
    mask = m;
    run_cycles(FRAME * n);
  endtask

  initial begin
    logic [15:0] rm;
    int          sel;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_row", row, 4'b1110);
    check("rst_key", key, 4'h0);
    check("rst_valid", {3'b0, key_valid}, 4'h0);
    check("rst_held", {3'b0, key_held}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;

    // Idle scanning
    frames('0, 2);

    // Clean press of key 6, then release
    pulses = 0;
    frames(K_R1C2, 6);
    check("clean_pulses", 4'(pulses), 4'd1);
    check("clean_key", key, 4'h6);
    frames('0, 2);
    check("clean_held_2empty", {3'b0, key_held}, 4'd1);
    frames('0, 1);
    check("clean_released", {3'b0, key_held}, 4'd0);
    check("clean_key_kept", key, 4'h6);

    // Bounce rejection
    pulses = 0;
    frames(K_R0C0, 2);
    frames('0, 1);
    check("bounce_no_pulse", 4'(pulses), 4'd0);
    frames(K_R0C0, 3);
    check("bounce_pulses", 4'(pulses), 4'd1);
    check("bounce_key", key, 4'h1);
    frames('0, 3);

    // Priority, then an extra key while held
    pulses = 0;
    frames(K_R2C0 | K_R0C3, 3);
    check("prio_key", key, 4'hA);
    frames(K_R2C0 | K_R0C3 | K_R3C1, 2);
    check("prio_pulses", 4'(pulses), 4'd1);
    check("prio_key_kept", key, 4'hA);
    frames('0, 3);

    // Key code zero
    pulses = 0;
    frames(K_R3C1, 3);
    check("zero_pulses", 4'(pulses), 4'd1);
    check("zero_key", key, 4'h0);
    check("zero_held", {3'b0, key_held}, 4'd1);
    frames('0, 3);
    check("zero_released", {3'b0, key_held}, 4'd0);

    // Asynchronous reset while pressed
    frames(K_R2C3, 4);
    check("mid_held", {3'b0, key_held}, 4'd1);
    check("mid_key", key, 4'hC);
    run_cycles(5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_held", {3'b0, key_held}, 4'd0);
    check("mid_rst_key", key, 4'h0);
    check("mid_rst_valid", {3'b0, key_valid}, 4'd0);
    check("mid_rst_row", row, 4'b1110);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    pulses = 0;
    frames(K_R2C3, 3);
    check("mid_after_pulses", 4'(pulses), 4'd1);
    check("mid_after_key", key, 4'hC);
    frames('0, 3);

    // Random key sequences
    repeat (24) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) rm = '0;
      else if (sel == 3) rm = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      else rm = 16'h1 << $urandom_range(0, 15);
      frames(rm, int'($urandom_range(1, 5)));
    end
    frames('0, 4);
    check("final_released", {3'b0, key_held}, 4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
